// File: rtl/ttt_nxn_game_if.sv
// Move handshake, status and cell read-back bundle for the NxN tic-tac-toe engine.
// master = controller/display side, slave = the game engine.
interface ttt_nxn_game_if #(
  parameter int N = 3
);
  localparam int CW = (N < 2) ? 1 : $clog2(N);

  logic          new_game;
  logic          move_valid;
  logic          move_ready;
  logic [CW-1:0] data_in_x;
  logic [CW-1:0] data_in_y;
  logic          move_err;
  logic [1:0]    player;
  logic [1:0]    winner;
  logic          draw;
  logic          stop_game;
  logic [CW-1:0] rd_x;
  logic [CW-1:0] rd_y;
  logic [1:0]    rd_cell;

  modport master (
    output new_game, move_valid, data_in_x, data_in_y, rd_x, rd_y,
    input  move_ready, move_err, player, winner, draw, stop_game, rd_cell
  );

  modport slave (
    input  new_game, move_valid, data_in_x, data_in_y, rd_x, rd_y,
    output move_ready, move_err, player, winner, draw, stop_game, rd_cell
  );
endinterface

// File: rtl/ttt_nxn_game.sv
// NxN tic-tac-toe engine with K-in-a-row win detection, move rejection,
// draw detection, synchronous restart and combinational cell read-back.
module ttt_nxn_game #(
  parameter int N = 3,
  parameter int K = 3
) (
  input logic            clk,
  input logic            reset,
  ttt_nxn_game_if.slave  bus
);
  localparam int CW = (N < 2) ? 1 : $clog2(N);
  localparam int MW = $clog2(N * N + 1);
  localparam logic [CW:0]   EDGE_LEN = (CW + 1)'(N);
  localparam logic [MW-1:0] FULL_CNT = MW'(N * N);

  typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

  state_t        state;
  logic [1:0]    board [N][N];
  logic [CW-1:0] last_x;
  logic [CW-1:0] last_y;
  logic [MW-1:0] move_cnt;
  logic [1:0]    player_q;
  logic [1:0]    winner_q;
  logic          draw_q;
  logic          stop_q;
  logic          err_q;

  logic          in_range;
  logic          legal;
  logic          win;

  // Legality of the presented move: on the board and landing on an empty cell.
  always_comb begin
    in_range = ({1'b0, bus.data_in_x} < EDGE_LEN) && ({1'b0, bus.data_in_y} < EDGE_LEN);
    legal    = 1'b0;
    if (in_range)
      legal = (board[bus.data_in_y][bus.data_in_x] == 2'b00);
  end

  // Cell read-back; addresses off the board report 3.
  always_comb begin
    bus.rd_cell = 2'b11;
    if (({1'b0, bus.rd_x} < EDGE_LEN) && ({1'b0, bus.rd_y} < EDGE_LEN))
      bus.rd_cell = board[bus.rd_y][bus.rd_x];
  end

  // Count the mover's contiguous run through the latched cell on all four lines.
  always_comb begin : line_check
    int   dx;
    int   dy;
    int   run;
    int   sgn;
    int   xx;
    int   yy;
    logic go;
    win = 1'b0;
    dx  = 0;
    dy  = 0;
    run = 0;
    sgn = 0;
    xx  = 0;
    yy  = 0;
    go  = 1'b0;
    for (int unsigned d = 0; d < 4; d++) begin
      case (d)
        0:       begin dx = 1; dy = 0;  end
        1:       begin dx = 0; dy = 1;  end
        2:       begin dx = 1; dy = 1;  end
        default: begin dx = 1; dy = -1; end
      endcase
      run = 1;
      for (int unsigned s = 0; s < 2; s++) begin
        sgn = (s == 0) ? 1 : -1;
        go  = 1'b1;
        for (int unsigned i = 1; i < K; i++) begin
          xx = int'(last_x) + sgn * int'(i) * dx;
          yy = int'(last_y) + sgn * int'(i) * dy;
          if (go && xx >= 0 && xx < N && yy >= 0 && yy < N) begin
            if (board[CW'(yy)][CW'(xx)] == player_q)
              run = run + 1;
            else
              go = 1'b0;
          end else begin
            go = 1'b0;
          end
        end
      end
      if (run >= K)
        win = 1'b1;
    end
  end

  // Game FSM: board writes, move counting, outcome registration and restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      board    <= '{default: '0};
      last_x   <= '0;
      last_y   <= '0;
      move_cnt <= '0;
      player_q <= 2'd1;
      winner_q <= 2'd0;
      draw_q   <= 1'b0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (bus.new_game) begin
      state    <= PLAY;
      board    <= '{default: '0};
      move_cnt <= '0;
      player_q <= 2'd1;
      winner_q <= 2'd0;
      draw_q   <= 1'b0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          err_q <= 1'b0;
          if (bus.move_valid) begin
            if (legal) begin
              board[bus.data_in_y][bus.data_in_x] <= player_q;
              last_x   <= bus.data_in_x;
              last_y   <= bus.data_in_y;
              move_cnt <= move_cnt + MW'(1);
              state    <= CHECK;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          err_q <= 1'b0;
          if (win) begin
            winner_q <= player_q;
            stop_q   <= 1'b1;
            state    <= OVER;
          end else if (move_cnt == FULL_CNT) begin
            draw_q <= 1'b1;
            stop_q <= 1'b1;
            state  <= OVER;
          end else begin
            player_q <= (player_q == 2'd1) ? 2'd2 : 2'd1;
            state    <= PLAY;
          end
        end
        OVER: begin
          err_q <= bus.move_valid;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

  assign bus.move_ready = (state != CHECK);
  assign bus.move_err   = err_q;
  assign bus.player     = player_q;
  assign bus.winner     = winner_q;
  assign bus.draw       = draw_q;
  assign bus.stop_game  = stop_q;
endmodule

// File: tb/tb_ttt_nxn_game.sv
// Bench for ttt_nxn_game: a 3x3/K=3 and a 5x5/K=4 engine driven side by side,
// checked against a board model that scans every line for K-in-a-row.
module tb_ttt_nxn_game;
  logic clk;
  logic reset;

  ttt_nxn_game_if #(.N(3)) i3 ();
  ttt_nxn_game_if #(.N(5)) i5 ();

  ttt_nxn_game #(.N(3), .K(3)) dut3 (.clk(clk), .reset(reset), .bus(i3.slave));
  ttt_nxn_game #(.N(5), .K(4)) dut5 (.clk(clk), .reset(reset), .bus(i5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, one per engine (index 0 = 3x3, 1 = 5x5).
  int mb [2][8][8];
  int m_n [2] = '{3, 5};
  int m_k [2] = '{3, 4};
  int m_pl [2];
  int m_win [2];
  int m_draw [2];
  int m_cnt [2];
  bit m_over [2];

  logic       o_ready, o_err, o_draw, o_stop;
  logic [1:0] o_player, o_winner;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int s);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        mb[s][y][x] = 0;
    m_pl[s] = 1; m_win[s] = 0; m_draw[s] = 0; m_cnt[s] = 0; m_over[s] = 0;
  endtask

  // Whole-board scan: does player p own any K consecutive cells on any line?
  function automatic bit model_won(input int s, input int p);
    int dxs [4] = '{1, 0, 1, 1};
    int dys [4] = '{0, 1, 1, -1};
    for (int y = 0; y < m_n[s]; y++)
      for (int x = 0; x < m_n[s]; x++)
        for (int d = 0; d < 4; d++) begin
          bit all = 1;
          for (int k = 0; k < m_k[s]; k++) begin
            int xx = x + k * dxs[d];
            int yy = y + k * dys[d];
            if (xx < 0 || yy < 0 || xx >= m_n[s] || yy >= m_n[s]) all = 0;
            else if (mb[s][yy][xx] != p) all = 0;
          end
          if (all) return 1;
        end
    return 0;
  endfunction

  task automatic drive(input int s, input bit v, input int x, input int y);
    if (s == 0) begin
      i3.move_valid = v; i3.data_in_x = 2'(x); i3.data_in_y = 2'(y);
    end else begin
      i5.move_valid = v; i5.data_in_x = 3'(x); i5.data_in_y = 3'(y);
    end
  endtask

  task automatic drive_ng(input int s, input bit v);
    if (s == 0) i3.new_game = v;
    else        i5.new_game = v;
  endtask

  task automatic sample(input int s);
    if (s == 0) begin
      o_ready = i3.move_ready; o_err = i3.move_err; o_player = i3.player;
      o_winner = i3.winner; o_draw = i3.draw; o_stop = i3.stop_game;
    end else begin
      o_ready = i5.move_ready; o_err = i5.move_err; o_player = i5.player;
      o_winner = i5.winner; o_draw = i5.draw; o_stop = i5.stop_game;
    end
  endtask

  task automatic rd(input int s, input int x, input int y, output logic [1:0] c);
    if (s == 0) begin i3.rd_x = 2'(x); i3.rd_y = 2'(y); end
    else        begin i5.rd_x = 3'(x); i5.rd_y = 3'(y); end
    #1;
    c = (s == 0) ? i3.rd_cell : i5.rd_cell;
  endtask

  task automatic check_status(input int s, input string tag);
    sample(s);
    check({tag, "_winner"}, o_winner, m_win[s]);
    check({tag, "_draw"}, o_draw, m_draw[s]);
    check({tag, "_stop"}, o_stop, (m_win[s] != 0 || m_draw[s] != 0));
    check({tag, "_player"}, o_player, m_pl[s]);
  endtask

  task automatic check_board(input int s);
    logic [1:0] c;
    for (int y = 0; y < m_n[s]; y++)
      for (int x = 0; x < m_n[s]; x++) begin
        rd(s, x, y, c);
        check($sformatf("cell%0d_%0d_%0d", s, x, y), c, mb[s][y][x]);
      end
    rd(s, m_n[s], 0, c);
    check("rd_oob_x", c, 3);
    rd(s, 0, m_n[s], c);
    check("rd_oob_y", c, 3);
  endtask

  // One move: present at a negedge, check rejection or the CHECK cycle and outcome.
  task automatic play(input int s, input int x, input int y);
    bit legal;
    logic [1:0] c;
    legal = !m_over[s] && x < m_n[s] && y < m_n[s] && mb[s][y][x] == 0;
    @(negedge clk);
    drive(s, 1'b1, x, y);
    sample(s);
    check("ready_pre", o_ready, 1);
    @(posedge clk); #1;
    drive(s, 1'b0, 0, 0);
    sample(s);
    check("move_err", o_err, !legal);
    if (legal) begin
      mb[s][y][x] = m_pl[s];
      m_cnt[s]++;
      check("ready_check", o_ready, 0);
      @(posedge clk); #1;
      if (model_won(s, m_pl[s])) begin
        m_win[s] = m_pl[s]; m_over[s] = 1;
      end else if (m_cnt[s] == m_n[s] * m_n[s]) begin
        m_draw[s] = 1; m_over[s] = 1;
      end else begin
        m_pl[s] = 3 - m_pl[s];
      end
      check_status(s, "after_check");
      check("ready_post", o_ready, 1);
      check("err_post", o_err, 0);
      rd(s, x, y, c);
      check("cell_written", c, mb[s][y][x]);
    end else begin
      check_status(s, "rejected");
    end
  endtask

  task automatic restart(input int s, input bit with_move, input int x, input int y);
    @(negedge clk);
    drive_ng(s, 1'b1);
    if (with_move) drive(s, 1'b1, x, y);
    @(posedge clk); #1;
    drive_ng(s, 1'b0);
    drive(s, 1'b0, 0, 0);
    model_clear(s);
    check_status(s, "new_game");
    check("ng_ready", o_ready, 1);
    check("ng_err", o_err, 0);
    check_board(s);
  endtask

  initial begin
    logic [1:0] c;
    int draw_seq [9][2] = '{'{0,0}, '{1,1}, '{2,2}, '{0,2}, '{2,0}, '{1,0}, '{1,2}, '{2,1}, '{0,1}};
    int anti_seq [7][2] = '{'{4,0}, '{0,0}, '{3,1}, '{0,1}, '{2,2}, '{0,2}, '{1,3}};

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      drive(s, 1'b0, 0, 0);
      drive_ng(s, 1'b0);
      model_clear(s);
    end
    i3.rd_x = '0; i3.rd_y = '0; i5.rd_x = '0; i5.rd_y = '0;
    #3;
    for (int s = 0; s < 2; s++) begin
      check_status(s, "reset");
      sample(s);
      check("reset_err", o_err, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sample(s);
      check("reset_ready", o_ready, 1);
      check_board(s);
    end

    // Row win for P1 on the 3x3 engine, then a move after the game is over.
    play(0, 0, 0); play(0, 0, 1); play(0, 1, 0); play(0, 1, 1); play(0, 2, 0);
    sample(0);
    check("row_win_winner", o_winner, 1);
    check("row_win_stop", o_stop, 1);
    play(0, 2, 2);
    check_board(0);

    // Restart from OVER, then occupied-cell and off-board rejections.
    restart(0, 1'b0, 0, 0);
    play(0, 1, 1);
    play(0, 1, 1);
    sample(0);
    check("occupied_player", o_player, 2);
    rd(0, 1, 1, c);
    check("occupied_cell", c, 1);
    play(0, 3, 0);
    rd(0, 3, 0, c);
    check("rd_x3", c, 3);

    // Full board with no line: draw.
    restart(0, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) play(0, draw_seq[i][0], draw_seq[i][1]);
    sample(0);
    check("draw_flag", o_draw, 1);
    check("draw_winner", o_winner, 0);
    check("draw_stop", o_stop, 1);

    // Restart from OVER with a move presented in the same cycle: move dropped.
    restart(0, 1'b1, 1, 1);

    // move_valid held across CHECK: only the first cell is written.
    @(negedge clk);
    drive(0, 1'b1, 0, 0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1, 0);
    sample(0);
    check("hold_ready_check", o_ready, 0);
    check("hold_err_check", o_err, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0);
    mb[0][0][0] = 1; m_cnt[0] = 1; m_pl[0] = 2;
    sample(0);
    check("hold_err_after", o_err, 0);
    check("hold_ready_after", o_ready, 1);
    check_status(0, "hold");
    check_board(0);

    // 5x5, K=4: three-long anti-diagonal is no win, the fourth completes it.
    for (int i = 0; i < 7; i++) begin
      play(1, anti_seq[i][0], anti_seq[i][1]);
      if (i == 4) begin
        sample(1);
        check("k4_three_nowin", o_winner, 0);
      end
    end
    sample(1);
    check("k4_anti_winner", o_winner, 1);
    check_board(1);

    // Random games on both engines.
    for (int g = 0; g < 8; g++) begin
      int s = g % 2;
      int extra = 0;
      restart(s, 1'b0, 0, 0);
      for (int t = 0; t < 60 && extra < 3; t++) begin
        int x, y, lim;
        lim = (s == 0) ? 3 : 7;
        if ($urandom_range(0, 3) != 0) begin
          x = $urandom_range(0, m_n[s] - 1); y = $urandom_range(0, m_n[s] - 1);
        end else begin
          x = $urandom_range(0, lim); y = $urandom_range(0, lim);
        end
        play(s, x, y);
        if (m_over[s]) extra++;
      end
      check_board(s);
    end

    // Reset asserted while the 3x3 engine sits in CHECK.
    restart(0, 1'b0, 0, 0);
    @(negedge clk);
    drive(0, 1'b1, 2, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0);
    sample(0);
    check("midcheck_ready", o_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      model_clear(s);
      check_status(s, "midcheck_reset");
      sample(s);
      check("midcheck_reset_ready", o_ready, 1);
      check("midcheck_reset_err", o_err, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    check_board(0);
    check_board(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
